// File: rtl/led_seq_ctrl.sv
// Command-driven LED pattern sequencer: blink, walking-one or bounce, stepped
// from a prescaled base tick, with an optional step count that ends in a done pulse.
module led_seq_ctrl #(
  parameter int NUM_LED  = 4,
  parameter int CNT_TICK = 125_000_000,
  parameter int PERIOD_W = 8,
  parameter int REPEAT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic [REPEAT_W-1:0] cmd_repeat,
  output logic [NUM_LED-1:0]  led_out,
  output logic                busy,
  output logic                done
);

  localparam int PRE_W = (CNT_TICK > 1) ? $clog2(CNT_TICK) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CNT_TICK - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {M_OFF, M_BLINK, M_SHIFT, M_BOUNCE} mode_t;

  state_t              state;
  mode_t               mode_q;
  mode_t               cmd_mode_e;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] per_cnt;
  logic [REPEAT_W-1:0] repeat_q;
  logic [REPEAT_W-1:0] step_cnt;
  logic [REPEAT_W-1:0] step_inc;
  logic [PRE_W-1:0]    pre_cnt;
  logic                dir_down;
  logic                next_dir;
  logic [NUM_LED-1:0]  led_q;
  logic [NUM_LED-1:0]  next_led;
  logic                busy_q;
  logic                done_q;
  logic                accept;
  logic                tick;
  logic                step_now;
  logic                finish;

  assign cmd_mode_e = mode_t'(cmd_mode);
  assign cmd_ready  = (state != S_DONE);
  assign accept     = cmd_valid & cmd_ready;
  assign tick       = (state == S_RUN) && (pre_cnt == PRE_MAX);
  assign step_now   = tick && (per_cnt == period_q - 1'b1);
  // With repeat=0 the step counter saturates so it can never wrap into a false match.
  assign step_inc   = (&step_cnt) ? step_cnt : step_cnt + 1'b1;
  assign finish     = (repeat_q != '0) && (step_inc == repeat_q);

  assign led_out = led_q;
  assign busy    = busy_q;
  assign done    = done_q;

  always_comb begin
    next_led = led_q;
    next_dir = dir_down;
    case (mode_q)
      M_BLINK: next_led = ~led_q;
      M_SHIFT: next_led = (led_q << 1) | (led_q >> (NUM_LED - 1));
      M_BOUNCE: begin
        if (NUM_LED > 1) begin
          // Direction flips as the lit bit lands on an end, so the reversal shows on the next step.
          if (!dir_down) begin
            next_led = led_q << 1;
            if (next_led[NUM_LED-1]) next_dir = 1'b1;
          end else begin
            next_led = led_q >> 1;
            if (next_led[0]) next_dir = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      mode_q   <= M_OFF;
      period_q <= PERIOD_W'(1);
      repeat_q <= '0;
      per_cnt  <= '0;
      step_cnt <= '0;
      pre_cnt  <= '0;
      dir_down <= 1'b0;
      led_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        pre_cnt  <= '0;
        per_cnt  <= '0;
        step_cnt <= '0;
        dir_down <= 1'b0;
        if (cmd_mode_e == M_OFF) begin
          state  <= S_IDLE;
          led_q  <= '0;
          busy_q <= 1'b0;
        end else begin
          mode_q   <= cmd_mode_e;
          period_q <= (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;
          repeat_q <= cmd_repeat;
          state    <= S_RUN;
          busy_q   <= 1'b1;
          led_q    <= (cmd_mode_e == M_BLINK) ? '1 : NUM_LED'(1);
        end
      end else begin
        case (state)
          S_RUN: begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) per_cnt <= step_now ? '0 : per_cnt + 1'b1;
            if (step_now) begin
              led_q    <= next_led;
              dir_down <= next_dir;
              step_cnt <= step_inc;
              if (finish) begin
                state  <= S_DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule
